// File: rtl/cdc_pkg.sv
// Shared types for the four-phase req/ack CDC handshake blocks.
// Pure declarations: no logic, no latency, no flow control.
// Provides the transmitter state encoding and the minimum synchronizer depth.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } cdc_tx_state_e;

    localparam int CDC_MIN_SYNC = 2;

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Bundle for the CDC transmitter: upstream valid/ready word stream plus the req/ack/data crossing.
// master = transmitter side, slave = the surrounding logic (upstream source and destination responder).
// No logic inside; the bundle adds no latency and no flow control of its own.
interface cdc_hs_tx_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack_async;
    logic              busy;
    logic              tx_done;

    modport master (
        input  in_valid, in_data, tx_ack_async,
        output in_ready, tx_req, tx_data, busy, tx_done
    );

    modport slave (
        output in_valid, in_data, tx_ack_async,
        input  in_ready, tx_req, tx_data, busy, tx_done
    );
endinterface

// File: rtl/ack_sync.sv
// Single-bit multi-flop synchronizer for a level crossing into the clk domain.
// Latency STAGES clock edges from d to q; a level signal, so there is no backpressure.
// All stages clear on asynchronous active-low reset.
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sff <= '0;
        end else begin
            sff <= {sff[STAGES-2:0], d};
        end
    end

    assign q = sff[STAGES-1];
endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a four-phase req/ack crossing; optional one-word skid buffer under CDC_HS_TX_SKID_EN.
// Latency: accept -> tx_req one edge; ack rise -> req fall SYNC_STAGES+1 edges; tx_done one cycle after ack_s seen low.
// Backpressure: in_ready low while a handshake (or leftover ack) is in flight, or once the skid word is held.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    cdc_hs_tx_if.master  bus
);
    generate
        if (SYNC_STAGES < CDC_MIN_SYNC) begin : g_bad_sync
            $error("cdc_hs_tx: SYNC_STAGES must be >= CDC_MIN_SYNC");
        end
    endgenerate

    cdc_tx_state_e     state;
    logic              ack_s;
    logic              in_ready;
    logic              accept;
    logic              tx_req;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;

    ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.tx_ack_async),
        .q     (ack_s)
    );

`ifdef CDC_HS_TX_SKID_EN
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;

    assign in_ready = (state == IDLE) ? !ack_s : !buf_valid;
`else
    assign in_ready = (state == IDLE) && !ack_s;
`endif

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= '0;
            tx_done <= 1'b0;
`ifdef CDC_HS_TX_SKID_EN
            buf_data  <= '0;
            buf_valid <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
`ifdef CDC_HS_TX_SKID_EN
            // Words taken while busy park in the skid register until DROP exits.
            if (state != IDLE && accept) begin
                buf_data  <= bus.in_data;
                buf_valid <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data <= bus.in_data;
                        tx_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        tx_req <= 1'b0;
                        state  <= DROP;
                    end
                end
                DROP: begin
                    if (!ack_s) begin
                        tx_done <= 1'b1;
`ifdef CDC_HS_TX_SKID_EN
                        // Chain straight into the next request; ack is already low here.
                        if (buf_valid) begin
                            tx_data   <= buf_data;
                            buf_valid <= 1'b0;
                            tx_req    <= 1'b1;
                            state     <= REQ;
                        end else if (accept) begin
                            tx_data   <= bus.in_data;
                            buf_valid <= 1'b0;
                            tx_req    <= 1'b1;
                            state     <= REQ;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    tx_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.tx_req   = tx_req;
    assign bus.tx_data  = tx_data;
    assign bus.tx_done  = tx_done;
    assign bus.busy     = (state != IDLE);
endmodule
